// File: rtl/tri_dispatch.sv
// Two-requester triangle dispatcher: round-robin grant, 144-bit serial push to
// the rasterizer, then pixel counting with a watchdog until the triangle is done.
module tri_dispatch #(
  parameter logic [21:0] TIMEOUT = 22'd2500000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ0,
  input  logic [143:0] TRI0,
  output logic         GNT0,
  input  logic         REQ1,
  input  logic [143:0] TRI1,
  output logic         GNT1,
  output logic         SD,
  output logic         SSTART,
  input  logic         RVALID,
  input  logic         RDONE,
  output logic         BUSY,
  output logic [16:0]  CNT,
  output logic         CNT_VALID,
  output logic         SRC,
  output logic         TOUT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam logic [7:0] LAST_BIT = 8'd143;

  state_t         state;
  state_t         state_nxt;
  logic [143:0]   shift_q;
  logic [7:0]     bit_cnt;
  logic [16:0]    pix_cnt;
  logic [21:0]    wd_cnt;
  logic           last_gnt;
  logic           src_int;
  logic           gnt0_q;
  logic           gnt1_q;
  logic [16:0]    cnt_q;
  logic           src_q;

  logic           grant;
  logic           winner;
  logic           wd_expired;
  logic [16:0]    pix_next;

  function automatic logic [16:0] sat_inc(input logic [16:0] v, input logic inc);
    if (inc && (v != 17'h1FFFF)) return v + 17'd1;
    return v;
  endfunction

  always_comb begin
    grant      = REQ0 | REQ1;
    // On a tie the requester not granted last wins; a lone request always wins.
    winner     = (REQ0 && REQ1) ? ~last_gnt : REQ1;
    wd_expired = (wd_cnt == TIMEOUT);
    pix_next   = sat_inc(pix_cnt, RVALID);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_nxt = WAIT;
      WAIT: begin
        if (RDONE)           state_nxt = REPORT;
        else if (wd_expired) state_nxt = IDLE;
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      pix_cnt  <= '0;
      wd_cnt   <= '0;
      last_gnt <= 1'b1;
      src_int  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      cnt_q    <= '0;
      src_q    <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            gnt0_q   <= ~winner;
            gnt1_q   <= winner;
            shift_q  <= winner ? TRI1 : TRI0;
            src_int  <= winner;
            last_gnt <= winner;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          shift_q <= {shift_q[142:0], 1'b0};
          bit_cnt <= bit_cnt + 8'd1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            pix_cnt <= '0;
            wd_cnt  <= '0;
          end
        end
        WAIT: begin
          pix_cnt <= pix_next;
          wd_cnt  <= wd_cnt + 22'd1;
          // Result is published on the RDONE edge so it is stable during REPORT.
          if (RDONE) begin
            cnt_q <= pix_next;
            src_q <= src_int;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    GNT0      = gnt0_q;
    GNT1      = gnt1_q;
    SSTART    = (state == SHIFT);
    SD        = (state == SHIFT) & shift_q[143];
    BUSY      = (state != IDLE);
    CNT_VALID = (state == REPORT);
    TOUT      = (state == WAIT) & wd_expired & ~RDONE;
    CNT       = cnt_q;
    SRC       = src_q;
  end

endmodule
